// File: rtl/design205_pkg.sv
// Shared constants and helpers for the design205 half-word multiply/rotate datapath.
package design205_pkg;

    localparam int WIDTH = 32;
    localparam int HALF  = 16;

    localparam logic [WIDTH-1:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [WIDTH-1:0] SAT_MIN = 32'h8000_0000;

    function automatic logic [WIDTH-1:0] rot_half(input logic [WIDTH-1:0] word);
        return {word[HALF-1:0], word[WIDTH-1:HALF]};
    endfunction

    // Overflow is only possible when both operands share a sign and the raw sum flips it.
    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] raw;
        raw = a + b;
        if (!a[WIDTH-1] && !b[WIDTH-1] && raw[WIDTH-1]) begin
            return SAT_MAX;
        end else if (a[WIDTH-1] && b[WIDTH-1] && !raw[WIDTH-1]) begin
            return SAT_MIN;
        end
        return raw;
    endfunction

endpackage

// File: rtl/design205_mul16.sv
// Combinational signed 16x16 -> 32 multiplier placed between the two pipeline stages.
module design205_mul16 (
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [31:0] p
);

    assign p = a * b;

endmodule

// File: rtl/design205_datapath.sv
// Two-stage datapath: out = hi*lo + rotate16(in), registered twice.
// Define DESIGN205_DATAPATH_SAT_EN to make the final add saturate instead of wrap.
module design205_datapath
    import design205_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0]  a_d, a_q;
    logic [WIDTH-1:0]  out_d, out_q;
    logic signed [15:0] hi, lo;
    logic signed [31:0] p;
    logic [WIDTH-1:0]  r;

    always_comb begin
        a_d = in;
        hi  = a_q[31:16];
        lo  = a_q[15:0];
    end

    design205_mul16 u_mul (
        .a (hi),
        .b (lo),
        .p (p)
    );

    always_comb begin
        r = rot_half(a_q);
`ifdef DESIGN205_DATAPATH_SAT_EN
        out_d = sat_add(p, r);
`else
        out_d = p + r;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            out_q <= '0;
        end else begin
            a_q   <= a_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_design205_datapath.sv
// Scoreboard bench for design205_datapath: expected words are queued when driven and popped two edges later.
module tb_design205_datapath;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] in_w;
    logic [31:0] out_w;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    design205_datapath #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .in  (in_w),
        .out (out_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built on 64-bit signed arithmetic, independent of the RTL's bit tricks.
    function automatic logic [31:0] refModel(input logic [31:0] w);
        longint hi, lo, prod, rot, sum;
        logic [31:0] rot_bits;
        hi       = longint'($signed(w[31:16]));
        lo       = longint'($signed(w[15:0]));
        prod     = hi * lo;
        rot_bits = {w[15:0], w[31:16]};
        rot      = longint'($signed(rot_bits));
        sum      = prod + rot;
`ifdef DESIGN205_DATAPATH_SAT_EN
        if (sum > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (sum < -64'sd2147483648) return 32'h8000_0000;
`endif
        return sum[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drives one word, advances one edge, then compares the word that has reached out.
    task automatic applyStimulus(input string tag, input logic [31:0] word,
                                 input logic [31:0] expected);
        exp_t e;
        in_w  = word;
        e.tag = tag;
        e.exp = expected;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            checkOutput(e.tag, out_w, e.exp);
        end else begin
            checkOutput("sb_underflow", 32'(sb.size()), 32'd2);
        end
    endtask

    // After reset a_q is zero, so the first post-reset output is zero.
    task automatic primeAfterReset();
        exp_t e;
        sb.delete();
        e.tag = "post_reset_zero";
        e.exp = 32'h0;
        sb.push_back(e);
    endtask

    logic [31:0] ovf_exp;
    logic [31:0] rw;

    initial begin
`ifdef DESIGN205_DATAPATH_SAT_EN
        ovf_exp = 32'h7FFF_FFFF;
`else
        ovf_exp = 32'hBFFE_8000;
`endif
        rst  = 1'b1;
        in_w = 32'h0;
        #1;
        checkOutput("reset_initial", out_w, 32'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("reset_hold", out_w, 32'h0);
        end
        rst = 1'b0;
        primeAfterReset();

        applyStimulus("basic",    32'h0002_0003, 32'h0003_0008);
        applyStimulus("neg",      32'hABCD_EFAB, 32'hF50A_D0BC);
        applyStimulus("zero",     32'h0000_0000, 32'h0000_0000);
        applyStimulus("overflow", 32'h7FFF_7FFF, ovf_exp);
        applyStimulus("neg_ovf",  32'h8000_8000, refModel(32'h8000_8000));
        applyStimulus("flush",    32'h0000_0000, 32'h0000_0000);

        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                #2;
                rst = 1'b1;
                #1;
                checkOutput("async_reset", out_w, 32'h0);
                @(posedge clk);
                #1;
                checkOutput("reset_midstream", out_w, 32'h0);
                rst = 1'b0;
                primeAfterReset();
            end
            rw = $urandom;
            applyStimulus("random", rw, refModel(rw));
        end
        applyStimulus("final_flush", 32'h0000_0000, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=%0d expected=%0d", checks, 1012);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/design205_datapath.md
# design205_datapath

Two-stage pipelined signed arithmetic datapath. Each 32-bit input word is split into two signed 16-bit halves; the block multiplies the halves and adds the product to the half-word-rotated input. It is a self-contained leaf in the random-design regression set, compared cycle-for-cycle against its synthesized netlist.

## Interface
- `WIDTH`, default 32: data word width. Fixed at 32; other values are unsupported.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in`  in  32  signed input word, sampled every rising edge.
- `out`  out  32  signed result, registered.

## Operation
- Stage 1 register: `a <= in`.
- Halves of `a`:
  - `hi = $signed(a[31:16])`
  - `lo = $signed(a[15:0])`
- Product: `p = hi * lo`, a full signed 32-bit result. It cannot overflow, because the 16x16 signed product fits in 32 bits.
- Rotate: `r = {a[15:0], a[31:16]}`, i.e. rotate by 16 and reinterpret as signed.
- Sum: `s = p + r`, a 32-bit signed add.
  - Default: wraps modulo 2^32.
  - Saturating variant: see Configuration.
- Stage 2 register: `out <= s`.
- No handshake; a new word is accepted every cycle with full throughput.
- Combinational logic stays purely between the `a` register and the `out` register. No other state exists.

## Timing
- Latency is 2 rising edges. A word sampled on edge k appears on `out` after edge k+1 and holds until edge k+2.
- Reset (`rst=1`) asynchronously clears `a` and `out` to 0, independent of `clk`.
  - While `rst` is held: `out = 0`.
  - After deassertion: the first edge loads `a`, and `out` becomes valid after the second edge.
- Reset asserted mid-stream: both stages are cleared immediately. In-flight words are discarded and never appear on `out`.
- Input 0 gives `p = 0` and `r = 0`, so `out = 0`. The output after reset is therefore indistinguishable from a zero input.

## Configuration
- Macro: `DESIGN205_DATAPATH_SAT_EN`.
- Undefined (default): `s` wraps modulo 2^32.
- Defined: `s` saturates on signed overflow.
  - Two positive operands with a negative raw sum give `s = 0x7FFFFFFF`.
  - Two negative operands with a non-negative raw sum give `s = 0x80000000`.
  - Otherwise `s` equals the raw sum.
- Latency, reset and interface are identical in both builds.

## Structure
- Package `design205_pkg`:
  - constants `WIDTH = 32` and `HALF = 16`
  - `SAT_MAX = 32'h7FFFFFFF` and `SAT_MIN = 32'h80000000`
  - function `rot_half(word)` that swaps the halves
  - function `sat_add(a, b)`
- Sub-module `design205_mul16`: a combinational signed 16x16 to 32 multiplier, instantiated once between the stages.
- Top level contains the two register stages, the rotate and the adder/saturator.

## Test plan
- Reset: hold `rst=1` with `in=0` for 2 cycles -> `out = 0`. Assert `rst` asynchronously between edges -> `out` goes to 0 without waiting for a clock edge.
- Basic: `in = 0x00020003` -> 2 edges later `out = 0x00030008`. Working: p = 6, r = 0x00030002.
- Negative halves: `in = 0xABCDEFAB` -> `out = 0xF50AD0BC`. Working: p = 0x055F24EF, r = 0xEFABABCD, no overflow; both builds give the same result.
- Overflow: `in = 0x7FFF7FFF` gives p = 0x3FFF0001 and r = 0x7FFF7FFF.
  - Default build -> `out = 0xBFFE8000`.
  - `DESIGN205_DATAPATH_SAT_EN` build -> `out = 0x7FFFFFFF`.
- Streaming: apply `0x00020003`, `0xABCDEFAB`, `0` on consecutive edges -> `out` shows `0x00030008`, `0xF50AD0BC`, `0`, each delayed by exactly 2 edges. Then apply 1000 random words and check every output against a reference model, including assertion of `rst` mid-stream.
